// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase timer: phase encodings,
// duration-register select codes and the phase sequencing rule.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_RED    = 2'd2
   } phase_t;

   localparam logic [1:0] CFG_SEL_GREEN  = 2'd0;
   localparam logic [1:0] CFG_SEL_YELLOW = 2'd1;
   localparam logic [1:0] CFG_SEL_RED    = 2'd2;
   localparam logic [1:0] CFG_SEL_NONE   = 2'd3;

   // The unused encoding folds back to RED so the sequence always recovers.
   function automatic logic [1:0] next_phase(input logic [1:0] ph);
      case (ph)
         PH_GREEN:  next_phase = PH_YELLOW;
         PH_YELLOW: next_phase = PH_RED;
         PH_RED:    next_phase = PH_GREEN;
         default:   next_phase = PH_RED;
      endcase
   endfunction

endpackage

// File: rtl/phase_len_regs.sv
// Runtime-programmable phase durations. Each output is the count value
// loaded at the start of that phase, with a zero length treated as one.
module phase_len_regs
   import traffic_pkg::*;
#(
   parameter int CW         = 6,
   parameter int DEF_GREEN  = 40,
   parameter int DEF_YELLOW = 5,
   parameter int DEF_RED    = 45
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cfg_we,
   input  logic [1:0]    i_cfg_sel,
   input  logic [CW-1:0] i_cfg_data,
   output logic [CW-1:0] o_load_green,
   output logic [CW-1:0] o_load_yellow,
   output logic [CW-1:0] o_load_red
);

   logic [CW-1:0] r_len  [0:2];
   logic [CW-1:0] w_load [0:2];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_len
         localparam int DEF_LEN = (gi == 0) ? DEF_GREEN :
                                  (gi == 1) ? DEF_YELLOW : DEF_RED;

         always_ff @(posedge clk) begin
            if (rst)
               r_len[gi] <= CW'(DEF_LEN);
            else if (i_cfg_we && (i_cfg_sel == 2'(gi)))
               r_len[gi] <= i_cfg_data;
         end

         // count runs len-1 .. 0; a stored zero still yields one tick
         assign w_load[gi] = (r_len[gi] == '0) ? '0 : r_len[gi] - CW'(1);
      end
   endgenerate

   assign o_load_green  = w_load[CFG_SEL_GREEN];
   assign o_load_yellow = w_load[CFG_SEL_YELLOW];
   assign o_load_red    = w_load[CFG_SEL_RED];

endmodule

// File: rtl/traffic_phase_timer.sv
// Per-phase countdown timer: GREEN -> YELLOW -> RED -> GREEN, each phase
// lasting a programmable number of ticks, with warn and phase-change pulse.
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int CW         = 6,
   parameter int DEF_GREEN  = 40,
   parameter int DEF_YELLOW = 5,
   parameter int DEF_RED    = 45,
   parameter int WARN_TH    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          pause,
   input  logic          force_red,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [CW-1:0] cfg_data,
   output logic [CW-1:0] count,
   output logic [1:0]    phase,
   output logic          warn,
   output logic          phase_done
);

   localparam logic [CW-1:0] RST_COUNT = (DEF_RED > 0) ? CW'(DEF_RED - 1) : '0;

   logic [CW-1:0] r_count;
   logic [1:0]    r_phase;
   logic          r_phase_done;
   logic [CW-1:0] w_load_green;
   logic [CW-1:0] w_load_yellow;
   logic [CW-1:0] w_load_red;
   logic [CW-1:0] w_load_next;

   phase_len_regs #(
      .CW         (CW),
      .DEF_GREEN  (DEF_GREEN),
      .DEF_YELLOW (DEF_YELLOW),
      .DEF_RED    (DEF_RED)
   ) u_len (
      .clk           (clk),
      .rst           (rst),
      .i_cfg_we      (cfg_we),
      .i_cfg_sel     (cfg_sel),
      .i_cfg_data    (cfg_data),
      .o_load_green  (w_load_green),
      .o_load_yellow (w_load_yellow),
      .o_load_red    (w_load_red)
   );

   always_comb begin
      w_load_next = w_load_red;
      case (next_phase(r_phase))
         PH_GREEN:  w_load_next = w_load_green;
         PH_YELLOW: w_load_next = w_load_yellow;
         default:   w_load_next = w_load_red;
      endcase
   end

   // Loads read the duration registers before any same-cycle write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase      <= PH_RED;
         r_count      <= RST_COUNT;
         r_phase_done <= 1'b0;
      end else if (force_red || (r_phase == CFG_SEL_NONE)) begin
         r_phase      <= PH_RED;
         r_count      <= w_load_red;
         r_phase_done <= 1'b1;
      end else if (pause) begin
         r_phase_done <= 1'b0;
      end else if (tick && (r_count == '0)) begin
         r_phase      <= next_phase(r_phase);
         r_count      <= w_load_next;
         r_phase_done <= 1'b1;
      end else if (tick) begin
         r_count      <= r_count - CW'(1);
         r_phase_done <= 1'b0;
      end else begin
         r_phase_done <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 1; gi++) begin : g_warn
         if (WARN_TH <= 0) begin : g_off
            assign warn = 1'b0;
         end else begin : g_on
            assign warn = ({1'b0, r_count} < (CW + 1)'(WARN_TH));
         end
      end
   endgenerate

   assign count      = r_count;
   assign phase      = r_phase;
   assign phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: a vector table for single-cycle
// priorities plus hand sequences for whole phases and corner cases.
module tb_traffic_phase_timer;

   localparam int CW = 6;
   localparam logic [1:0] G = 2'd0;
   localparam logic [1:0] Y = 2'd1;
   localparam logic [1:0] R = 2'd2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick = 1'b0;
   logic          pause = 1'b0;
   logic          force_red = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_sel = 2'd0;
   logic [CW-1:0] cfg_data = '0;
   logic [CW-1:0] count;
   logic [1:0]    phase;
   logic          warn;
   logic          phase_done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   traffic_phase_timer dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .pause      (pause),
      .force_red  (force_red),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .count      (count),
      .phase      (phase),
      .warn       (warn),
      .phase_done (phase_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst, tick, pause, frc, we;
      logic [1:0]    sel;
      logic [CW-1:0] data;
      logic [CW-1:0] ec;
      logic [1:0]    ep;
      logic          ed;
   } vec_t;

   vec_t vecs [15];

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic r, input logic t, input logic p, input logic f,
                      input logic w, input logic [1:0] s, input logic [CW-1:0] d);
      rst = r; tick = t; pause = p; force_red = f;
      cfg_we = w; cfg_sel = s; cfg_data = d;
      @(posedge clk);
      #1;
      rst = 1'b0; tick = 1'b0; pause = 1'b0; force_red = 1'b0; cfg_we = 1'b0;
      if (phase_done) n_pulses++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 2'd0, '0);
   endtask

   task automatic check(input string name, input logic [CW-1:0] ec,
                        input logic [1:0] ep, input logic ed);
      logic ew;
      ew = (ec < 5);
      n_checks++;
      if (count !== ec || phase !== ep || warn !== ew || phase_done !== ed) begin
         n_fail++;
         $display("FAIL %s: got count=%0d phase=%0d warn=%0b done=%0b, expected count=%0d phase=%0d warn=%0b done=%0b",
                  name, count, phase, warn, phase_done, ec, ep, ew, ed);
      end else begin
         $display("ok   %s: count=%0d phase=%0d warn=%0b done=%0b", name, count, phase, warn, phase_done);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("ok   %s: %0d", name, got);
      end
   endtask

   initial begin
      //          rst tick pause frc we  sel   data   ec   ep done
      vecs[0]  = '{1, 0, 0, 0, 0, 2'd0, 6'd0,  6'd44, R, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 2'd0, 6'd0,  6'd44, R, 0};
      vecs[2]  = '{0, 1, 0, 0, 0, 2'd0, 6'd0,  6'd43, R, 0};
      vecs[3]  = '{0, 1, 1, 0, 0, 2'd0, 6'd0,  6'd43, R, 0};
      vecs[4]  = '{0, 0, 0, 1, 0, 2'd0, 6'd0,  6'd44, R, 1};
      vecs[5]  = '{0, 1, 0, 0, 0, 2'd0, 6'd0,  6'd43, R, 0};
      vecs[6]  = '{0, 0, 0, 0, 1, 2'd3, 6'd7,  6'd43, R, 0};
      vecs[7]  = '{0, 1, 0, 1, 0, 2'd0, 6'd0,  6'd44, R, 1};
      vecs[8]  = '{0, 0, 1, 1, 0, 2'd0, 6'd0,  6'd44, R, 1};
      vecs[9]  = '{0, 0, 0, 0, 1, 2'd2, 6'd10, 6'd44, R, 0};
      vecs[10] = '{0, 0, 0, 1, 0, 2'd0, 6'd0,  6'd9,  R, 1};
      vecs[11] = '{0, 0, 0, 0, 1, 2'd2, 6'd0,  6'd9,  R, 0};
      vecs[12] = '{0, 0, 0, 1, 0, 2'd0, 6'd0,  6'd0,  R, 1};
      vecs[13] = '{0, 1, 0, 0, 0, 2'd0, 6'd0,  6'd39, G, 1};
      vecs[14] = '{1, 1, 0, 0, 0, 2'd0, 6'd0,  6'd44, R, 0};

      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].rst, vecs[i].tick, vecs[i].pause, vecs[i].frc,
             vecs[i].we, vecs[i].sel, vecs[i].data);
         check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ep, vecs[i].ed);
      end

      // RED countdown from reset, then the GREEN load, then a full cycle
      cyc(1, 0, 0, 0, 0, 2'd0, '0);
      check("reset", 6'd44, R, 0);
      n_pulses = 0;
      for (int i = 1; i <= 44; i++) begin
         cyc(0, 1, 0, 0, 0, 2'd0, '0);
         check($sformatf("red_tick%0d", i), 6'(44 - i), R, 0);
      end
      cyc(0, 1, 0, 0, 0, 2'd0, '0);
      check("red_to_green", 6'd39, G, 1);
      cyc(0, 0, 0, 0, 0, 2'd0, '0);
      check("done_one_cycle", 6'd39, G, 0);
      ticks(39);
      check("green_end", 6'd0, G, 0);
      cyc(0, 1, 0, 0, 0, 2'd0, '0);
      check("green_to_yellow", 6'd4, Y, 1);
      ticks(4);
      check("yellow_end", 6'd0, Y, 0);
      cyc(0, 1, 0, 0, 0, 2'd0, '0);
      check("yellow_to_red", 6'd44, R, 1);
      check_int("pulses_full_cycle", n_pulses, 3);

      // Shortened YELLOW written mid-GREEN, then a zero-length YELLOW
      cyc(1, 0, 0, 0, 0, 2'd0, '0);
      ticks(55);
      check("green_mid", 6'd29, G, 0);
      cyc(0, 0, 0, 0, 1, 2'd1, 6'd3);
      check("cfg_no_effect", 6'd29, G, 0);
      ticks(30);
      check("yellow3_load", 6'd2, Y, 1);
      ticks(1);
      check("yellow3_1", 6'd1, Y, 0);
      ticks(1);
      check("yellow3_0", 6'd0, Y, 0);
      ticks(1);
      check("yellow3_to_red", 6'd44, R, 1);
      cyc(0, 0, 0, 0, 1, 2'd1, 6'd0);
      ticks(85);
      check("yellow0_load", 6'd0, Y, 1);
      ticks(1);
      check("yellow0_to_red", 6'd44, R, 1);

      // Pause holds count and discards ticks; force_red overrides pause
      cyc(1, 0, 0, 0, 0, 2'd0, '0);
      ticks(64);
      check("pre_pause", 6'd20, G, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, 2'd0, '0);
      check("paused", 6'd20, G, 0);
      ticks(1);
      check("resume", 6'd19, G, 0);
      cyc(0, 1, 1, 1, 0, 2'd0, '0);
      check("force_in_pause", 6'd44, R, 1);

      // Same-cycle load and write uses the old length; reset beats tick
      cyc(1, 0, 0, 0, 0, 2'd0, '0);
      ticks(44);
      check("red_zero", 6'd0, R, 0);
      cyc(0, 1, 0, 0, 1, 2'd0, 6'd10);
      check("load_old_len", 6'd39, G, 1);
      ticks(90);
      check("load_new_len", 6'd9, G, 1);
      ticks(12);
      check("mid_yellow", 6'd2, Y, 0);
      cyc(1, 1, 0, 0, 0, 2'd0, '0);
      check("rst_over_tick", 6'd44, R, 0);
      ticks(45);
      check("green_default_back", 6'd39, G, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
